// File: rtl/case_3_div_pkg.sv
// Shared widths, iteration count and FSM state encoding for the sequential signed divider.
package case_3_div_pkg;

  localparam int unsigned DIN0_W = 15;
  localparam int unsigned DIN1_W = 7;
  localparam int unsigned DOUT_W = 15;
  localparam int unsigned N_ITER = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/case_3_sdiv_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor, keep or restore.
module case_3_sdiv_step #(
  parameter int unsigned W = 7
) (
  input  logic [W-1:0] rem_in,
  input  logic         din_bit,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_c,
  output logic         q_bit_c
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // Remainder stays below the divisor, so the kept value always fits in W bits.
  always_comb begin
    shifted = {rem_in, din_bit};
    trial   = shifted - {1'b0, dvs};
    q_bit_c = (shifted >= {1'b0, dvs});
    rem_c   = q_bit_c ? trial[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/case_3_sdiv_15s_7s_seq.sv
// Sequential signed divider: magnitude restoring division over 15 cycles, signs applied afterwards.
module case_3_sdiv_15s_7s_seq
  import case_3_div_pkg::*;
#(
  parameter int unsigned din0_WIDTH = DIN0_W,
  parameter int unsigned din1_WIDTH = DIN1_W,
  parameter int unsigned dout_WIDTH = DOUT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  dz,
  output logic                  ovf
);

  localparam int unsigned CNT_W = $clog2(N_ITER);

  state_t                  state;
  state_t                  state_nxt;
  logic [din0_WIDTH-1:0]   a_reg;
  logic [din1_WIDTH-1:0]   b_reg;
  logic [din1_WIDTH-1:0]   r_reg;
  logic                    neg_a;
  logic                    neg_b;
  logic [CNT_W-1:0]        cnt;
  logic [din1_WIDTH-1:0]   step_rem_c;
  logic                    step_q_c;
  logic [din0_WIDTH-1:0]   q_fix_c;
  logic [din1_WIDTH-1:0]   r_fix_c;
  logic                    ovf_fix_c;

  case_3_sdiv_step #(
    .W(din1_WIDTH)
  ) u_step (
    .rem_in (r_reg),
    .din_bit(a_reg[din0_WIDTH-1]),
    .dvs    (b_reg),
    .rem_c  (step_rem_c),
    .q_bit_c(step_q_c)
  );

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next state and handshake decode
  always_comb begin
    state_nxt = state;
    ap_ready  = 1'b0;
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          ap_ready  = 1'b1;
          state_nxt = S_INIT;
        end
      end
      S_INIT:  state_nxt = S_ITER;
      S_ITER:  if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE: begin
        ap_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sign restoration; a positive magnitude with its MSB set cannot be represented.
  always_comb begin
    q_fix_c   = (neg_a ^ neg_b) ? -a_reg : a_reg;
    r_fix_c   = neg_a ? -r_reg : r_reg;
    ovf_fix_c = !(neg_a ^ neg_b) && a_reg[din0_WIDTH-1];
  end

  // Datapath: a_reg holds the raw dividend, then its magnitude, then the quotient bits.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      r_reg <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      cnt   <= '0;
      quot  <= '0;
      rem   <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            a_reg <= din0;
            b_reg <= din1;
          end
        end
        S_INIT: begin
          neg_a <= a_reg[din0_WIDTH-1];
          neg_b <= b_reg[din1_WIDTH-1];
          a_reg <= a_reg[din0_WIDTH-1] ? -a_reg : a_reg;
          b_reg <= b_reg[din1_WIDTH-1] ? -b_reg : b_reg;
          r_reg <= '0;
          cnt   <= CNT_W'(N_ITER - 1);
        end
        S_ITER: begin
          a_reg <= {a_reg[din0_WIDTH-2:0], step_q_c};
          r_reg <= step_rem_c;
          cnt   <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          if (b_reg == '0) begin
            quot <= '1;
            rem  <= '0;
            dz   <= 1'b1;
            ovf  <= 1'b0;
          end else begin
            quot <= dout_WIDTH'(q_fix_c);
            rem  <= r_fix_c;
            dz   <= 1'b0;
            ovf  <= ovf_fix_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_case_3_sdiv_15s_7s_seq.sv
// Bench for the sequential signed divider: cycle-accurate arithmetic model plus directed vectors.
module tb_case_3_sdiv_15s_7s_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        ap_start = 1'b0;
  logic [14:0] din0 = '0;
  logic [6:0]  din1 = '0;
  logic        ap_idle;
  logic        ap_ready;
  logic        ap_done;
  logic [14:0] quot;
  logic [6:0]  rem;
  logic        dz;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 = idle, 1..18 = cycles since acceptance; results appear at phase 18.
  int          m_phase = 0;
  int          m_a = 0;
  int          m_d = 0;
  logic [14:0] m_q = '0;
  logic [6:0]  m_r = '0;
  logic        m_z = 1'b0;
  logic        m_o = 1'b0;
  logic [14:0] t_q;
  logic [6:0]  t_r;
  logic        t_z;
  logic        t_o;

  case_3_sdiv_15s_7s_seq dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .ap_start(ap_start),
    .din0    (din0),
    .din1    (din1),
    .ap_idle (ap_idle),
    .ap_ready(ap_ready),
    .ap_done (ap_done),
    .quot    (quot),
    .rem     (rem),
    .dz      (dz),
    .ovf     (ovf)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Plain integer division truncates toward zero; remainder takes the dividend's sign.
  task automatic model_div(input int a, input int d, output logic [14:0] q, output logic [6:0] r,
                           output logic z, output logic o);
    int qi;
    int ri;
    if (d == 0) begin
      q = 15'h7fff;
      r = '0;
      z = 1'b1;
      o = 1'b0;
    end else begin
      qi = a / d;
      ri = a % d;
      q  = qi[14:0];
      r  = ri[6:0];
      z  = 1'b0;
      o  = (qi > 16383);
    end
  endtask

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_phase <= 0;
      m_q     <= '0;
      m_r     <= '0;
      m_z     <= 1'b0;
      m_o     <= 1'b0;
    end else if (m_phase == 0) begin
      if (ap_start) begin
        m_phase <= 1;
        m_a     <= int'($signed(din0));
        m_d     <= int'($signed(din1));
      end
    end else begin
      if (m_phase == 17) begin
        model_div(m_a, m_d, t_q, t_r, t_z, t_o);
        m_q <= t_q;
        m_r <= t_r;
        m_z <= t_z;
        m_o <= t_o;
      end
      m_phase <= (m_phase == 18) ? 0 : m_phase + 1;
    end
  end

  always @(negedge ap_clk) begin
    if (chk_en) begin
      chk("m_idle",  32'(ap_idle),  32'(m_phase == 0));
      chk("m_ready", 32'(ap_ready), 32'((m_phase == 0) && ap_start));
      chk("m_done",  32'(ap_done),  32'(m_phase == 18));
      chk("m_quot",  32'(quot),     32'(m_q));
      chk("m_rem",   32'(rem),      32'(m_r));
      chk("m_dz",    32'(dz),       32'(m_z));
      chk("m_ovf",   32'(ovf),      32'(m_o));
    end
  end

  task automatic do_op(input int a, input int d, input int eq, input int er,
                       input bit edz, input bit eovf);
    int  cyc;
    bit  got;
    @(posedge ap_clk); #2;
    ap_start = 1'b1;
    din0     = 15'(a);
    din1     = 7'(d);
    @(negedge ap_clk);
    chk("accept_ready", 32'(ap_ready), 32'd1);
    @(posedge ap_clk); #2;
    ap_start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge ap_clk);
      cyc++;
      if (ap_done) got = 1'b1;
    end
    chk("latency", 32'(cyc), 32'd18);
    chk("quot", 32'(quot), 32'(eq) & 32'h7fff);
    chk("rem",  32'(rem),  32'(er) & 32'h7f);
    chk("dz",   32'(dz),   32'(edz));
    chk("ovf",  32'(ovf),  32'(eovf));
  endtask

  initial begin
    int rdy_cyc[$];
    int n_done;
    int cyc;
    #1 ap_rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge ap_clk);
    chk("rst_idle", 32'(ap_idle), 32'd1);
    chk("rst_done", 32'(ap_done), 32'd0);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem",  32'(rem),  32'd0);
    chk("rst_dz",   32'(dz),   32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;

    do_op(100, 7, 14, 2, 1'b0, 1'b0);
    do_op(-100, 7, -14, -2, 1'b0, 1'b0);
    do_op(100, -7, -14, 2, 1'b0, 1'b0);
    do_op(-16384, 7, -2340, -4, 1'b0, 1'b0);
    do_op(-16384, -64, 256, 0, 1'b0, 1'b0);
    do_op(1234, 0, -1, 0, 1'b1, 1'b0);
    do_op(-16384, -1, -16384, 0, 1'b0, 1'b1);

    // ap_start held high with operands changing every cycle.
    @(posedge ap_clk); #2;
    ap_start = 1'b1;
    for (int i = 0; i < 58; i++) begin
      din0 = 15'($urandom);
      din1 = 7'($urandom);
      @(negedge ap_clk);
      if (ap_ready) rdy_cyc.push_back(i);
      @(posedge ap_clk); #2;
    end
    ap_start = 1'b0;
    chk("hold_ready_count", 32'(rdy_cyc.size()), 32'd4);
    for (int i = 1; i < rdy_cyc.size(); i++)
      chk("hold_ready_gap", 32'(rdy_cyc[i] - rdy_cyc[i-1]), 32'd19);
    cyc = 0;
    do begin
      @(negedge ap_clk);
      cyc++;
    end while (!ap_idle && cyc < 40);
    chk("hold_back_idle", 32'(ap_idle), 32'd1);

    // Reset pulsed while iterating aborts the division.
    @(posedge ap_clk); #2;
    ap_start = 1'b1;
    din0     = 15'd1000;
    din1     = 7'd3;
    @(posedge ap_clk); #2;
    ap_start = 1'b0;
    repeat (6) @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    @(negedge ap_clk);
    chk("abort_idle", 32'(ap_idle), 32'd1);
    chk("abort_quot", 32'(quot), 32'd0);
    chk("abort_rem",  32'(rem),  32'd0);
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;
    n_done = 0;
    repeat (25) begin
      @(negedge ap_clk);
      if (ap_done) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    do_op(50, -3, -16, 2, 1'b0, 1'b0);

    repeat (2) @(negedge ap_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
